// File: rtl/riscv_32i_defs_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_32i_defs_pkg : shared RV32I datapath types and register-file constants
// Revision: 1.1
// ----------------------------------------------------------------------------
package riscv_32i_defs_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  rf_addr_t;

  localparam int RF_NUM_REGS = 32;
  localparam int RF_ADDR_W   = 5;
  localparam int RF_ZERO_REG = 0;

endpackage
`default_nettype wire

// File: rtl/reg_file_sb_intf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_file_sb_intf : observation bundle for the scoreboarded register file
// Revision: 1.1
// ----------------------------------------------------------------------------
interface reg_file_sb_intf
  import riscv_32i_defs_pkg::*;
#(
  parameter  int XLEN         = 32,
  parameter  int NUM_REGS     = RF_NUM_REGS,
  parameter  int NUM_RD_PORTS = 2,
  localparam int ADDR_W       = $clog2(NUM_REGS)
) (
  input logic clk
);

  logic                           rst;
  logic                           wr_en;
  logic [ADDR_W-1:0]              wr_reg;
  logic [XLEN-1:0]                wr_data;
  logic                           rsv_en;
  logic [ADDR_W-1:0]              rsv_reg;
  logic [NUM_RD_PORTS*ADDR_W-1:0] rd_reg;
  logic [NUM_RD_PORTS*XLEN-1:0]   rd_data;
  logic [NUM_RD_PORTS-1:0]        rd_busy;
  logic                           busy_any;

  modport monitor (
    input clk, rst, wr_en, wr_reg, wr_data, rsv_en, rsv_reg,
          rd_reg, rd_data, rd_busy, busy_any
  );

endinterface
`default_nettype wire

// File: rtl/reg_file_scoreboard.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_file_scoreboard : per-register busy bits, set by issue, cleared by writeback
// Revision: 1.1
// ----------------------------------------------------------------------------
module reg_file_scoreboard
  import riscv_32i_defs_pkg::*;
#(
  parameter  int NUM_REGS = RF_NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_reg,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_reg,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] busy_d;
  logic [NUM_REGS-1:0] busy_q;

  always_comb begin
    busy_d = busy_q;
    if (clr_en && (clr_reg != ADDR_W'(RF_ZERO_REG))) begin
      busy_d[clr_reg] = 1'b0;
    end
    // Set after clear: a new producer reserving the register outlives the old writeback.
    if (set_en && (set_reg != ADDR_W'(RF_ZERO_REG))) begin
      busy_d[set_reg] = 1'b1;
    end
    busy_d[RF_ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule
`default_nettype wire

// File: rtl/reg_file_sb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_file_sb : N-read/1-write register file with write bypass and busy scoreboard
// Revision: 1.1
// ----------------------------------------------------------------------------
module reg_file_sb
  import riscv_32i_defs_pkg::*;
#(
  parameter  int XLEN         = 32,
  parameter  int NUM_REGS     = RF_NUM_REGS,
  parameter  int NUM_RD_PORTS = 2,
  parameter  int BYPASS       = 1,
  localparam int ADDR_W       = $clog2(NUM_REGS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           wr_en,
  input  logic [ADDR_W-1:0]              wr_reg,
  input  logic [XLEN-1:0]                wr_data,
  input  logic                           rsv_en,
  input  logic [ADDR_W-1:0]              rsv_reg,
  input  logic [NUM_RD_PORTS*ADDR_W-1:0] rd_reg,
  output logic [NUM_RD_PORTS*XLEN-1:0]   rd_data,
  output logic [NUM_RD_PORTS-1:0]        rd_busy,
  output logic                           busy_any
);

  logic [XLEN-1:0]     regs_d [NUM_REGS];
  logic [XLEN-1:0]     regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_vec;
  logic                wr_valid;

  assign wr_valid = wr_en && (wr_reg != ADDR_W'(RF_ZERO_REG));

  always_comb begin
    regs_d = regs_q;
    if (wr_valid) begin
      regs_d[wr_reg] = wr_data;
    end
    regs_d[RF_ZERO_REG] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  reg_file_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (rsv_en),
    .set_reg  (rsv_reg),
    .clr_en   (wr_en),
    .clr_reg  (wr_reg),
    .busy_vec (busy_vec)
  );

  for (genvar i = 0; i < NUM_RD_PORTS; i++) begin : g_rd_port
    logic [ADDR_W-1:0] addr;
    logic              hit;

    assign addr = rd_reg[i*ADDR_W +: ADDR_W];
    // The writeback in flight is the newest value and also retires the busy bit.
    assign hit  = (BYPASS != 0) && wr_valid && (wr_reg == addr);
    assign rd_data[i*XLEN +: XLEN] = hit ? wr_data : regs_q[addr];
    assign rd_busy[i]              = hit ? 1'b0    : busy_vec[addr];
  end

  assign busy_any = |busy_vec[NUM_REGS-1:1];

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_reg_file_sb : directed and random checks of reg_file_sb, two configurations
// Revision: 1.1
// ----------------------------------------------------------------------------
module tb_reg_file_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Config A: 32 x 32, 2 read ports, bypass on
  logic         a_wr_en, a_rsv_en;
  logic [4:0]   a_wr_reg, a_rsv_reg;
  logic [31:0]  a_wr_data;
  logic [9:0]   a_rd_reg;
  logic [63:0]  a_rd_data;
  logic [1:0]   a_rd_busy;
  logic         a_busy_any;

  // Config B: 16 x 64, 4 read ports, bypass off
  logic         b_wr_en, b_rsv_en;
  logic [3:0]   b_wr_reg, b_rsv_reg;
  logic [63:0]  b_wr_data;
  logic [15:0]  b_rd_reg;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_busy;
  logic         b_busy_any;

  int tests = 0;
  int fails = 0;

  logic [31:0] ma [32];
  logic [31:0] ba;
  logic [63:0] mb [16];
  logic [15:0] bb;

  reg_file_sb #(
    .XLEN(32), .NUM_REGS(32), .NUM_RD_PORTS(2), .BYPASS(1)
  ) dut_a (
    .clk(clk), .rst(rst),
    .wr_en(a_wr_en), .wr_reg(a_wr_reg), .wr_data(a_wr_data),
    .rsv_en(a_rsv_en), .rsv_reg(a_rsv_reg),
    .rd_reg(a_rd_reg), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
    .busy_any(a_busy_any)
  );

  reg_file_sb #(
    .XLEN(64), .NUM_REGS(16), .NUM_RD_PORTS(4), .BYPASS(0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .wr_en(b_wr_en), .wr_reg(b_wr_reg), .wr_data(b_wr_data),
    .rsv_en(b_rsv_en), .rsv_reg(b_rsv_reg),
    .rd_reg(b_rd_reg), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
    .busy_any(b_busy_any)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rst = 1'b0;
    a_wr_en = 1'b0; a_wr_reg = '0; a_wr_data = '0;
    a_rsv_en = 1'b0; a_rsv_reg = '0; a_rd_reg = '0;
    b_wr_en = 1'b0; b_wr_reg = '0; b_wr_data = '0;
    b_rsv_en = 1'b0; b_rsv_reg = '0; b_rd_reg = '0;
  endtask

  // Expected read results derived from the architectural state plus the current inputs.
  task automatic model_chk();
    logic [4:0]  ra;
    logic [3:0]  rb;
    logic [63:0] ed;
    logic        eb;
    for (int i = 0; i < 2; i++) begin
      ra = a_rd_reg[i*5 +: 5];
      if (ra == 5'd0) begin
        ed = '0; eb = 1'b0;
      end else if (a_wr_en && a_wr_reg == ra) begin
        ed = 64'(a_wr_data); eb = 1'b0;
      end else begin
        ed = 64'(ma[ra]); eb = ba[ra];
      end
      chk($sformatf("a_model_data[%0d]", i), 64'(a_rd_data[i*32 +: 32]), ed);
      chk($sformatf("a_model_busy[%0d]", i), 64'(a_rd_busy[i]), 64'(eb));
    end
    chk("a_model_busy_any", 64'(a_busy_any), 64'(|ba[31:1]));
    for (int i = 0; i < 4; i++) begin
      rb = b_rd_reg[i*4 +: 4];
      ed = (rb == 4'd0) ? 64'd0 : mb[rb];
      eb = (rb == 4'd0) ? 1'b0 : bb[rb];
      chk($sformatf("b_model_data[%0d]", i), b_rd_data[i*64 +: 64], ed);
      chk($sformatf("b_model_busy[%0d]", i), 64'(b_rd_busy[i]), 64'(eb));
    end
    chk("b_model_busy_any", 64'(b_busy_any), 64'(|bb[15:1]));
  endtask

  task automatic sample();
    @(negedge clk);
    model_chk();
  endtask

  task automatic model_edge();
    @(posedge clk);
    if (rst) begin
      for (int k = 0; k < 32; k++) ma[k] = '0;
      for (int k = 0; k < 16; k++) mb[k] = '0;
      ba = '0;
      bb = '0;
    end else begin
      if (a_wr_en && a_wr_reg != 5'd0) begin ma[a_wr_reg] = a_wr_data; ba[a_wr_reg] = 1'b0; end
      if (a_rsv_en && a_rsv_reg != 5'd0) ba[a_rsv_reg] = 1'b1;
      if (b_wr_en && b_wr_reg != 4'd0) begin mb[b_wr_reg] = b_wr_data; bb[b_wr_reg] = 1'b0; end
      if (b_rsv_en && b_rsv_reg != 4'd0) bb[b_rsv_reg] = 1'b1;
    end
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    model_edge();

    // Reset clears written data and ignores concurrent write/reserve
    idle(); a_wr_en = 1'b1; a_wr_reg = 5'd5; a_wr_data = 32'hDEADBEEF;
    sample(); model_edge();
    idle(); a_rd_reg = {5'd0, 5'd5};
    sample();
    chk("a_x5_before_rst", 64'(a_rd_data[31:0]), 64'hDEADBEEF);
    rst = 1'b1; a_wr_en = 1'b1; a_wr_reg = 5'd5; a_wr_data = 32'h1;
    a_rsv_en = 1'b1; a_rsv_reg = 5'd5;
    model_edge();
    idle(); a_rd_reg = {5'd0, 5'd5};
    sample();
    chk("rst_x5_data", 64'(a_rd_data[31:0]), 64'h0);
    chk("rst_x5_busy", 64'(a_rd_busy[0]), 64'h0);
    chk("rst_busy_any", 64'(a_busy_any), 64'h0);
    model_edge();

    // Register 0 ignores writes and reserves
    idle();
    a_wr_en = 1'b1; a_wr_reg = 5'd0; a_wr_data = 32'hFFFFFFFF;
    a_rsv_en = 1'b1; a_rsv_reg = 5'd0;
    b_wr_en = 1'b1; b_wr_reg = 4'd0; b_wr_data = '1;
    sample();
    chk("r0_same_cycle_data", 64'(a_rd_data[31:0]), 64'h0);
    model_edge();
    idle();
    sample();
    chk("r0_data", 64'(a_rd_data[31:0]), 64'h0);
    chk("r0_busy", 64'(a_rd_busy[0]), 64'h0);
    chk("r0_busy_any", 64'(a_busy_any), 64'h0);
    chk("b_r0_data", b_rd_data[63:0], 64'h0);
    model_edge();

    // Bypass on A, no bypass on B
    idle();
    a_wr_en = 1'b1; a_wr_reg = 5'd7; a_wr_data = 32'h12345678; a_rd_reg = {5'd7, 5'd0};
    b_wr_en = 1'b1; b_wr_reg = 4'd7; b_wr_data = 64'h12345678; b_rd_reg = {4'd0, 4'd0, 4'd7, 4'd0};
    sample();
    chk("a_bypass_data", 64'(a_rd_data[63:32]), 64'h12345678);
    chk("a_bypass_busy", 64'(a_rd_busy[1]), 64'h0);
    chk("b_nobypass_old", b_rd_data[127:64], 64'h0);
    model_edge();
    idle(); b_rd_reg = {4'd0, 4'd0, 4'd7, 4'd0};
    sample();
    chk("b_nobypass_new", b_rd_data[127:64], 64'h12345678);
    model_edge();

    // Scoreboard lifecycle on x3
    idle(); a_rsv_en = 1'b1; a_rsv_reg = 5'd3; a_rd_reg = {5'd0, 5'd3};
    sample();
    chk("sb_rsv_same_cycle", 64'(a_rd_busy[0]), 64'h0);
    model_edge();
    idle(); a_rd_reg = {5'd0, 5'd3};
    sample();
    chk("sb_busy_n1", 64'(a_rd_busy[0]), 64'h1);
    chk("sb_busy_any_n1", 64'(a_busy_any), 64'h1);
    model_edge();
    sample(); model_edge();
    a_wr_en = 1'b1; a_wr_reg = 5'd3; a_wr_data = 32'hA5A5A5A5;
    sample();
    chk("sb_wr_bypass_busy", 64'(a_rd_busy[0]), 64'h0);
    model_edge();
    idle(); a_rd_reg = {5'd0, 5'd3};
    sample();
    chk("sb_data_n4", 64'(a_rd_data[31:0]), 64'hA5A5A5A5);
    chk("sb_busy_n4", 64'(a_rd_busy[0]), 64'h0);
    chk("sb_busy_any_n4", 64'(a_busy_any), 64'h0);
    model_edge();

    // Write and reserve of the same register on one edge
    idle(); a_rsv_en = 1'b1; a_rsv_reg = 5'd9;
    sample(); model_edge();
    idle(); a_wr_en = 1'b1; a_wr_reg = 5'd9; a_wr_data = 32'h1;
    a_rsv_en = 1'b1; a_rsv_reg = 5'd9; a_rd_reg = {5'd0, 5'd9};
    sample(); model_edge();
    idle(); a_rd_reg = {5'd0, 5'd9};
    sample();
    chk("wr_rsv_data", 64'(a_rd_data[31:0]), 64'h1);
    chk("wr_rsv_busy", 64'(a_rd_busy[0]), 64'h1);
    a_wr_en = 1'b1; a_wr_reg = 5'd9; a_wr_data = 32'h2;
    model_edge();
    idle(); a_rd_reg = {5'd0, 5'd9};
    sample();
    chk("wr2_data", 64'(a_rd_data[31:0]), 64'h2);
    chk("wr2_busy", 64'(a_rd_busy[0]), 64'h0);
    chk("wr2_busy_any", 64'(a_busy_any), 64'h0);
    model_edge();

    // All four B ports alias x15
    idle(); b_wr_en = 1'b1; b_wr_reg = 4'd15; b_wr_data = 64'h0123456789ABCDEF;
    sample(); model_edge();
    idle(); b_rd_reg = {4{4'd15}};
    sample();
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("b_alias_port%0d", p), b_rd_data[p*64 +: 64], 64'h0123456789ABCDEF);
    end
    model_edge();

    // Random write/reserve/read traffic on both configurations
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 63) == 0);
      a_wr_en   = $urandom_range(0, 1) == 1;
      a_wr_reg  = 5'($urandom_range(0, 7));
      a_wr_data = $urandom;
      a_rsv_en  = $urandom_range(0, 2) == 0;
      a_rsv_reg = 5'($urandom_range(0, 7));
      a_rd_reg  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      b_wr_en   = $urandom_range(0, 1) == 1;
      b_wr_reg  = 4'($urandom);
      b_wr_data = {$urandom, $urandom};
      b_rsv_en  = $urandom_range(0, 2) == 0;
      b_rsv_reg = 4'($urandom);
      b_rd_reg  = 16'($urandom);
      sample();
      model_edge();
    end

    idle();
    sample();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the single-write, dual-read register file.
- Generalised in width, depth and read-port count; adds an optional write-to-read bypass and a per-register busy scoreboard.
- Sits in the decode stage of the pipelined core. Read ports serve operand fetch, the write port serves writeback, and the reserve port is driven by issue to mark pending destinations.
- Register 0 is hardwired to zero and is never busy.

Parameters:
- XLEN, 32, data width in bits.
- NUM_REGS, 32, number of architectural registers; power of two, >= 2.
- NUM_RD_PORTS, 2, number of independent read ports; 1..4.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching read ports.
- Derived localparam ADDR_W = $clog2(NUM_REGS).

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- wr_en, input, 1, writeback enable.
- wr_reg, input, ADDR_W, writeback destination.
- wr_data, input, XLEN, writeback data.
- rsv_en, input, 1, reserve enable from issue.
- rsv_reg, input, ADDR_W, register to mark busy.
- rd_reg, input, NUM_RD_PORTS x ADDR_W, read addresses.
- rd_data, output, NUM_RD_PORTS x XLEN, read data.
- rd_busy, output, NUM_RD_PORTS x 1, operand-pending flag per read port.
- busy_any, output, 1, OR of all busy bits (pipeline-drain indicator).

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: on a rising clk edge with rst=1, all registers become 0 and all busy bits clear. The reset edge ignores wr_en and rsv_en. Outputs follow combinationally: rd_data=0, rd_busy=0, busy_any=0.
- Reset mid-operation: pending reservations are discarded, and there is no replay.
- Reads: combinational, zero latency. rd_data[i] = regs[rd_reg[i]]. All ports are independent, and any number may alias the same register.
- Register 0: rd_data=0 and rd_busy=0 always. A write to reg 0 is dropped. A reserve of reg 0 is dropped.
- Write: when wr_en=1 and wr_reg!=0, regs[wr_reg] <= wr_data on the edge. The same edge clears busy[wr_reg] unless overridden by a reserve (see below).
- Bypass, BYPASS=1: when wr_en=1, wr_reg!=0 and rd_reg[i]==wr_reg, then in the same cycle rd_data[i]=wr_data and rd_busy[i]=0.
- Bypass, BYPASS=0: rd_data shows the old value and rd_busy shows the pre-edge busy bit until the next cycle.
- Reserve: when rsv_en=1 and rsv_reg!=0, busy[rsv_reg] <= 1. The reserve takes no effect on reads in the same cycle; rd_busy reflects it from the next cycle.
- Simultaneous write and reserve, same register: data is written AND busy ends at 1, because the new producer wins.
- Simultaneous write and reserve, different registers: both take effect independently.
- Write to a non-busy register: permitted, data updates, busy stays 0. This is not an error.
- Reserve of an already-busy register: busy stays 1 (idempotent). There is no counting; one write clears it.
- busy_any: combinational OR of busy[NUM_REGS-1:1].
- No X propagation: out-of-range addresses cannot occur because NUM_REGS is a power of two.

Decomposition:
- Shared package riscv_32i_defs_pkg:
  - Existing word_t and rf_addr_t remain the default XLEN=32, NUM_REGS=32 types.
  - Add constants RF_NUM_REGS=32, RF_ADDR_W=5 and RF_ZERO_REG=0.
- The block uses parametrised logic vectors internally, so non-default sizes do not depend on package typedefs.
- Sub-module reg_file_scoreboard:
  - Holds the busy-bit vector plus the reserve/clear/priority logic.
  - Ports: clk, rst, set_en, set_reg, clr_en, clr_reg, busy_vec.
- The top level instantiates it and adds the storage array, read muxes and bypass.
- Extend the existing monitor interface: a parametrised reg_file_sb_intf with a monitor modport adding rsv_en, rsv_reg, rd_busy and busy_any.

Test Plan:
- Reset: write x5=0xDEADBEEF, then assert rst for 1 cycle -> rd_reg[0]=5 reads 0x00000000; rd_busy=0; busy_any=0.
- Register 0: wr_en=1, wr_reg=0, wr_data=0xFFFFFFFF; also rsv_reg=0 -> rd_reg=0 returns 0, rd_busy=0, busy_any=0 next cycle.
- Bypass, BYPASS=1: wr x7=0x12345678 while rd_reg[1]=7 in the same cycle -> rd_data[1]=0x12345678 and rd_busy[1]=0 that cycle. With BYPASS=0 the same stimulus -> old value 0x00000000, new value the next cycle.
- Scoreboard lifecycle: rsv x3 at cycle N -> rd_busy=1 from N+1. Write x3=0xA5A5A5A5 at N+3 -> rd_busy=0 and data 0xA5A5A5A5 from N+4, with busy_any 1→0.
- Simultaneous write and reserve: x9 busy; write x9=0x1 and reserve x9 on the same edge -> data 0x1, busy stays 1. A second write x9=0x2 -> busy 0.
- Multi-port aliasing, NUM_RD_PORTS=4, XLEN=64, NUM_REGS=16: all four ports read x15=0x0123456789ABCDEF -> identical data on all ports. A random write/reserve sequence is checked against a reference model.
